// File: rtl/tick_mon_pkg.sv
// Shared types and default parameters for the tick period monitor.
package tick_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_e;

  localparam int DEF_WIDTH      = 17;
  localparam int DEF_PERIOD     = 65536;
  localparam int DEF_TOL        = 2;
  localparam int DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/tick_period_monitor_interval_counter.sv
// Cycles-since-last-tick counter with window and timeout classification.
module tick_interval_counter #(
  parameter int WIDTH  = tick_mon_pkg::DEF_WIDTH,
  parameter int PERIOD = tick_mon_pkg::DEF_PERIOD,
  parameter int TOL    = tick_mon_pkg::DEF_TOL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             in_window_o,
  output logic             timeout_o
);

  localparam logic [WIDTH-1:0] WIN_LO  = WIDTH'(PERIOD - TOL);
  localparam logic [WIDTH-1:0] WIN_HI  = WIDTH'(PERIOD + TOL);
  localparam logic [WIDTH-1:0] TO_VAL  = WIDTH'(PERIOD + TOL + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // A tick restarts at 1 so the value sampled on the next tick is the distance.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_i)                cnt_d = WIDTH'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign in_window_o = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
  // Equality (not >=) makes the strobe fire once per missing tick.
  assign timeout_o   = !tick_i && (cnt_q == TO_VAL);

endmodule

// File: rtl/tick_period_monitor.sv
// Tick period monitor: measures tick spacing, tracks lock, flags bad periods.
// Optional TICK_MON_STATS_EN adds err_count and max_period outputs.
module tick_period_monitor
  import tick_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PERIOD     = DEF_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  output logic             locked,
  output logic             err,
  output logic [WIDTH-1:0] period,
  output logic [1:0]       state
`ifdef TICK_MON_STATS_EN
  ,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] max_period
`endif
);

  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  logic [WIDTH-1:0] cnt;
  logic             in_window, timeout;

  state_e           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic             err_q, err_d;
  logic             locked_q;
  logic [WIDTH-1:0] period_q, period_d;
  logic             capture;

  tick_interval_counter #(
    .WIDTH  (WIDTH),
    .PERIOD (PERIOD),
    .TOL    (TOL)
  ) u_cnt (
    .clk         (clk),
    .rst         (reset),
    .tick_i      (tick),
    .cnt_o       (cnt),
    .in_window_o (in_window),
    .timeout_o   (timeout)
  );

  assign capture = tick && (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    err_d    = 1'b0;
    period_d = capture ? cnt : period_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (tick) begin
          if (in_window) begin
            good_d = good_q + GW'(1);
            if (int'(good_q) + 1 >= LOCK_COUNT - 1) state_d = LOCKED;
          end else begin
            err_d  = 1'b1;
            good_d = '0;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = LOST;
        end
      end
      LOCKED: begin
        if (tick) begin
          if (!in_window) begin
            err_d   = 1'b1;
            good_d  = '0;
            state_d = ACQUIRE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = LOST;
        end
      end
      LOST: begin
        if (tick) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      good_q   <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
      period_q <= period_d;
    end
  end

  assign locked = locked_q;
  assign err    = err_q;
  assign period = period_q;
  assign state  = state_q;

`ifdef TICK_MON_STATS_EN
  logic [7:0]       err_count_q;
  logic [WIDTH-1:0] max_period_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q  <= '0;
      max_period_q <= '0;
    end else begin
      if (err_d && err_count_q != 8'hff) err_count_q <= err_count_q + 8'd1;
      if (capture && cnt > max_period_q) max_period_q <= cnt;
    end
  end

  assign err_count  = err_count_q;
  assign max_period = max_period_q;
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// Randomized bench for tick_period_monitor against a timestamp-based model.
module tb_tick_period_monitor;

  localparam int W   = 5;
  localparam int P   = 8;
  localparam int T   = 1;
  localparam int LC  = 4;
  localparam int SAT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic         locked, err;
  logic [W-1:0] period;
  logic [1:0]   state;
`ifdef TICK_MON_STATS_EN
  logic [7:0]   err_count;
  logic [W-1:0] max_period;
`endif

  tick_period_monitor #(.WIDTH(W), .PERIOD(P), .TOL(T), .LOCK_COUNT(LC)) dut (
    .clk    (clk),
    .reset  (rst),
    .tick   (tick),
    .locked (locked),
    .err    (err),
    .period (period),
    .state  (state)
`ifdef TICK_MON_STATS_EN
    ,
    .err_count  (err_count),
    .max_period (max_period)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Model: edges are numbered; a tick's period is the edge distance to the
  // previous tick (reset counts as a virtual tick one edge ahead).
  int m_k = 0, m_last = 0;
  int m_st = 0, m_g = 0, m_per = 0, m_err = 0;
  int ns, ng, np, ne, nl;

  function automatic void model_next(input int st, g, per, kn, last, input bit t,
                                     output int nst, output int ngood,
                                     output int nper, output int nerr,
                                     output int nlast);
    int d;
    bit inwin, tmo;
    d = kn - last;
    if (d > SAT) d = SAT;
    inwin = (d >= P - T) && (d <= P + T);
    tmo   = !t && (d == P + T + 1) && (st == 1 || st == 2);
    nst = st; ngood = g; nper = per; nerr = 0; nlast = last;
    if (t) begin
      nlast = kn;
      if (st != 0) nper = d;
    end
    if (st == 0) begin
      if (t) begin nst = 1; ngood = 0; end
    end else if (st == 1) begin
      if (t && inwin) begin
        ngood = g + 1;
        if (ngood >= LC - 1) nst = 2;
      end else if (t) begin
        nerr = 1; ngood = 0;
      end else if (tmo) begin
        nerr = 1; nst = 3;
      end
    end else if (st == 2) begin
      if (t && !inwin) begin
        nerr = 1; ngood = 0; nst = 1;
      end else if (tmo) begin
        nerr = 1; nst = 3;
      end
    end else begin
      if (t) begin nst = 1; ngood = 0; end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_g <= 0; m_per <= 0; m_err <= 0;
      m_last <= m_k + 1;
    end else begin
      model_next(m_st, m_g, m_per, m_k + 1, m_last, tick, ns, ng, np, ne, nl);
      m_st <= ns; m_g <= ng; m_per <= np; m_err <= ne; m_last <= nl;
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    chk("state",  int'(state),  m_st);
    chk("locked", int'(locked), (m_st == 2) ? 1 : 0);
    chk("err",    int'(err),    m_err);
    chk("period", int'(period), m_per);
  end

  task automatic step(input bit v);
    @(negedge clk);
    tick = v;
  endtask

  task automatic gap(input int n);
    repeat (n - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic lock_up();
    repeat (3) gap(P);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_state",  int'(state),  0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err",    int'(err),    0);
    chk("rst_period", int'(period), 0);
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state",  int'(state),  0);
    chk("reset_period", int'(period), 0);
    rst = 1'b0;

    // Lock with four ticks 8 apart.
    repeat (3) step(1'b0);
    step(1'b1); settle();
    chk("t1_acquire", int'(state), 1);
    gap(P); gap(P); settle();
    chk("t1_not_yet", int'(locked), 0);
    gap(P); settle();
    chk("t1_locked", int'(locked), 1);
    chk("t1_period", int'(period), 8);

    // Late tick while locked.
    gap(10); settle();
    chk("t2_err",    int'(err),    1);
    chk("t2_locked", int'(locked), 0);
    chk("t2_state",  int'(state),  1);
    chk("t2_period", int'(period), 10);
    step(1'b0); settle();
    chk("t2_err_once", int'(err), 0);

    // Missing ticks after relock.
    gap(P - 1); lock_up(); settle();
    chk("t3_locked", int'(locked), 1);
    repeat (10) step(1'b0);
    settle();
    chk("t3_timeout", int'(err),   1);
    chk("t3_lost",    int'(state), 3);
    step(1'b0); settle();
    chk("t3_err_once", int'(err), 0);
    repeat (5) step(1'b0);
    step(1'b1); settle();
    chk("t3_reacq", int'(state), 1);
    chk("t3_noerr", int'(err),   0);

    // Alternating 7/9 periods keep lock.
    lock_up();
    for (int i = 0; i < 3; i++) begin
      gap(7); settle();
      chk("t4_p7", int'(period), 7);
      chk("t4_lk", int'(locked), 1);
      gap(9); settle();
      chk("t4_p9", int'(period), 9);
      chk("t4_lk", int'(locked), 1);
    end

    // Back-to-back ticks in ACQUIRE clear the good count.
    gap(12); gap(P);
    step(1'b1); settle();
    chk("t5_err",    int'(err),    1);
    chk("t5_period", int'(period), 1);
    gap(P); gap(P); settle();
    chk("t5_still_acq", int'(state), 1);
    gap(P); settle();
    chk("t5_locked", int'(state), 2);

    // Asynchronous reset while locked.
    mid_reset();
    repeat (2) step(1'b0);
    step(1'b1); settle();
    chk("t6_acquire", int'(state), 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60)      gap($urandom_range(P - T, P + T));
      else if (r < 80) gap($urandom_range(1, 14));
      else if (r < 97) gap($urandom_range(10, 40));
      else             mid_reset();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
